// File: rtl/vme_wr_demux_10.sv
// vme_wr_demux_10: write-side byte demultiplexer for the VME slave.
// A byte from the write datapath is steered into one of ten holding
// registers selected by a 4-bit code (1111 -> reg0 ... 0110 -> reg9),
// with a four-phase req/ack handshake toward the slave control FSM.
module vme_wr_demux_10 #(
  parameter logic [79:0] RST_VAL = 80'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [3:0] sel,
  input  logic [7:0] din,
  output logic       wr_ack,
  output logic       wr_err,
  output logic [9:0] wr_stb,
  output logic [7:0] dout0,
  output logic [7:0] dout1,
  output logic [7:0] dout2,
  output logic [7:0] dout3,
  output logic [7:0] dout4,
  output logic [7:0] dout5,
  output logic [7:0] dout6,
  output logic [7:0] dout7,
  output logic [7:0] dout8,
  output logic [7:0] dout9
);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] sel_q;
  logic [7:0] din_q;
  logic [7:0] regs [10];
  logic       sel_valid;
  logic [3:0] sel_idx;

  // Decode the captured select; a case statement sends undefined codes
  // (including X/Z bits) to the invalid default rather than propagating X.
  always_comb begin
    sel_valid = 1'b1;
    sel_idx   = 4'd0;
    case (sel_q)
      4'b1111: sel_idx = 4'd0;
      4'b1110: sel_idx = 4'd1;
      4'b1101: sel_idx = 4'd2;
      4'b1100: sel_idx = 4'd3;
      4'b1011: sel_idx = 4'd4;
      4'b1010: sel_idx = 4'd5;
      4'b1001: sel_idx = 4'd6;
      4'b1000: sel_idx = 4'd7;
      4'b0111: sel_idx = 4'd8;
      4'b0110: sel_idx = 4'd9;
      default: sel_valid = 1'b0;
    endcase
  end

  // State register; reset returns to IDLE and aborts any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: WRITE lasts exactly one cycle, HOLD waits for wr_req to drop.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (wr_req) state_next = WRITE;
      WRITE:   state_next = HOLD;
      HOLD:    if (!wr_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture in IDLE, write and acknowledge in WRITE, release in HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 10; i++) begin
        regs[i] <= RST_VAL[8*i +: 8];
      end
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      wr_stb <= 10'b0;
      sel_q  <= 4'b0;
      din_q  <= 8'b0;
    end else begin
      case (state)
        IDLE: begin
          wr_stb <= 10'b0;
          if (wr_req) begin
            sel_q <= sel;
            din_q <= din;
          end
        end
        WRITE: begin
          wr_ack <= 1'b1;
          if (sel_valid) begin
            regs[sel_idx] <= din_q;
            wr_stb        <= 10'b1 << sel_idx;
          end else begin
            wr_err <= 1'b1;
            wr_stb <= 10'b0;
          end
        end
        HOLD: begin
          wr_stb <= 10'b0;
          if (!wr_req) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
          end
        end
        default: begin
          wr_stb <= 10'b0;
        end
      endcase
    end
  end

  assign dout0 = regs[0];
  assign dout1 = regs[1];
  assign dout2 = regs[2];
  assign dout3 = regs[3];
  assign dout4 = regs[4];
  assign dout5 = regs[5];
  assign dout6 = regs[6];
  assign dout7 = regs[7];
  assign dout8 = regs[8];
  assign dout9 = regs[9];

endmodule
